// File: rtl/prefetch_stride_gen_pkg.sv
// Shared prefetcher types: FSM state encoding and data-queue opcodes.
package prefetcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } pfState_t;

  localparam logic [2:0] OP_NOP               = 3'd0;
  localparam logic [2:0] OP_READ_REQ_PREF     = 3'd1;
  localparam logic [2:0] OP_READ_REQ_MASTER   = 3'd2;
  localparam logic [2:0] OP_READ_DATA_SLAVE   = 3'd3;
  localparam logic [2:0] OP_READ_DATA_PROMISE = 3'd4;

endpackage

// File: rtl/prefetch_stride_gen_if.sv
// Observed master AR traffic, queue backpressure and the prefetch request port.
interface prefetch_stride_gen_if #(
  parameter int ADDR_BITS = 64
);
  logic                 arValid;
  logic [ADDR_BITS-1:0] arAddr;
  logic                 queueAlmostFull;
  logic [2:0]           prefOpcode;
  logic [ADDR_BITS-1:0] prefAddr;

  modport master (
    output arValid, arAddr, queueAlmostFull,
    input  prefOpcode, prefAddr
  );

  modport slave (
    input  arValid, arAddr, queueAlmostFull,
    output prefOpcode, prefAddr
  );
endinterface

// File: rtl/prefetch_stride_gen_stride_detector.sv
// Combinational block-delta evaluation. Build option: PREFETCH_NEG_STRIDE_EN
// admits negative deltas as strides; otherwise only positive deltas train.
module stride_detector #(
  parameter int ADDR_BITS   = 64,
  parameter int STRIDE_BITS = 16
) (
  input  logic [ADDR_BITS-1:0]          blk_i,
  input  logic [ADDR_BITS-1:0]          lastBlk_i,
  input  logic signed [STRIDE_BITS-1:0] stride_i,
  output logic                          inRange_o,
  output logic signed [STRIDE_BITS-1:0] deltaStride_o,
  output logic                          match_o,
  output logic                          hit_o
);
  logic [ADDR_BITS-1:0] delta;
  logic                 fits;

  assign delta = blk_i - lastBlk_i;
  // Fits in signed STRIDE_BITS when all bits above the stride sign bit copy it.
  assign fits  = (&delta[ADDR_BITS-1:STRIDE_BITS-1]) | ~(|delta[ADDR_BITS-1:STRIDE_BITS-1]);

`ifdef PREFETCH_NEG_STRIDE_EN
  assign inRange_o = fits & (|delta);
`else
  assign inRange_o = fits & (|delta) & ~delta[ADDR_BITS-1];
`endif

  assign deltaStride_o = inRange_o ? signed'(delta[STRIDE_BITS-1:0]) : '0;
  assign match_o       = inRange_o && (delta[STRIDE_BITS-1:0] == stride_i);
  assign hit_o         = (blk_i == lastBlk_i + ADDR_BITS'(stride_i));
endmodule

// File: rtl/prefetch_stride_gen.sv
// Stride prefetch request generator: trains on AR block deltas and issues
// readReqPref into idle request-port cycles. Build option: PREFETCH_NEG_STRIDE_EN.
module prefetch_stride_gen
  import prefetcher_pkg::*;
#(
  parameter int ADDR_BITS            = 64,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int STRIDE_BITS          = 16,
  parameter int CONF_WIDTH           = 2,
  parameter int DEPTH_WIDTH          = 3
) (
  input  logic                          clk,
  input  logic                          resetN,
  prefetch_stride_gen_if.slave          bus,
  input  logic                          crs_enable,
  input  logic [CONF_WIDTH-1:0]         crs_confThreshold,
  input  logic [DEPTH_WIDTH-1:0]        crs_prefDepth,
  output logic signed [STRIDE_BITS-1:0] curStride,
  output logic [DEPTH_WIDTH-1:0]        aheadCnt,
  output logic [1:0]                    state
);
  pfState_t                    state_q;
  logic [ADDR_BITS-1:0]        lastBlk_q, nextPref_q, prefAddr_q;
  logic signed [STRIDE_BITS-1:0] stride_q, stride_d;
  logic [CONF_WIDTH-1:0]       conf_q, conf_d;
  logic [DEPTH_WIDTH-1:0]      aheadCnt_q;
  logic [2:0]                  prefOpcode_q;

  logic [ADDR_BITS-1:0]        blk;
  logic                        inRange, match, hit, issue;
  logic signed [STRIDE_BITS-1:0] deltaStride;

  function automatic logic [CONF_WIDTH-1:0] conf_inc(input logic [CONF_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [ADDR_BITS-1:0] sext(input logic signed [STRIDE_BITS-1:0] s);
    return ADDR_BITS'(s);
  endfunction

  assign blk = bus.arAddr >> LOG_BLOCK_DATA_BYTES;

  stride_detector #(
    .ADDR_BITS   (ADDR_BITS),
    .STRIDE_BITS (STRIDE_BITS)
  ) u_det (
    .blk_i         (blk),
    .lastBlk_i     (lastBlk_q),
    .stride_i      (stride_q),
    .inRange_o     (inRange),
    .deltaStride_o (deltaStride),
    .match_o       (match),
    .hit_o         (hit)
  );

  // Training update as seen by an AR in TRAIN.
  assign stride_d = match ? stride_q : deltaStride;
  assign conf_d   = match ? conf_inc(conf_q) : '0;

  // Demand always owns the shared port; prefetch only fills idle cycles.
  assign issue = (state_q == ACTIVE) && !bus.arValid && !bus.queueAlmostFull &&
                 (aheadCnt_q < crs_prefDepth) && crs_enable;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      lastBlk_q    <= '0;
      nextPref_q   <= '0;
      prefAddr_q   <= '0;
      stride_q     <= '0;
      conf_q       <= '0;
      aheadCnt_q   <= '0;
      prefOpcode_q <= OP_NOP;
    end else if (!crs_enable) begin
      state_q      <= IDLE;
      stride_q     <= '0;
      conf_q       <= '0;
      aheadCnt_q   <= '0;
      prefOpcode_q <= OP_NOP;
    end else begin
      prefOpcode_q <= issue ? OP_READ_REQ_PREF : OP_NOP;
      if (issue) begin
        prefAddr_q <= nextPref_q << LOG_BLOCK_DATA_BYTES;
        nextPref_q <= nextPref_q + sext(stride_q);
        aheadCnt_q <= aheadCnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.arValid) begin
            lastBlk_q <= blk;
            state_q   <= TRAIN;
          end
        end
        TRAIN: begin
          if (bus.arValid) begin
            lastBlk_q <= blk;
            stride_q  <= stride_d;
            conf_q    <= conf_d;
            if (conf_d >= crs_confThreshold) begin
              state_q    <= ACTIVE;
              nextPref_q <= blk + sext(stride_d);
              aheadCnt_q <= '0;
            end
          end
        end
        ACTIVE: begin
          if (bus.arValid) begin
            lastBlk_q <= blk;
            if (hit) begin
              // Demand caught up with the prefetch front: restart ahead of it.
              if (aheadCnt_q != '0) aheadCnt_q <= aheadCnt_q - 1'b1;
              else                  nextPref_q <= blk + sext(stride_q);
            end else begin
              state_q    <= TRAIN;
              conf_q     <= '0;
              stride_q   <= deltaStride;
              aheadCnt_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.prefOpcode = prefOpcode_q;
  assign bus.prefAddr   = prefAddr_q;
  assign curStride      = stride_q;
  assign aheadCnt       = aheadCnt_q;
  assign state          = state_q;

  logic unused_ok;
  assign unused_ok = inRange;
endmodule
